// File: rtl/reg_wb_queue_if.sv
// Bundle of the write-back queue's producer, register-file and snoop signals.
// The slave modport is the queue itself; the master modport is its environment.
interface reg_wb_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_WIDTH-1:0] m_waddr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_waddr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic                  hit1;
  logic                  hit2;
  logic [DATA_WIDTH-1:0] fwd_data1;
  logic [DATA_WIDTH-1:0] fwd_data2;
  logic [CW-1:0]         count;

  modport slave (
    input  m_valid, m_waddr, m_wdata, a_valid, a_waddr, a_wdata, raddr1, raddr2,
    output m_ready, a_ready, wen, waddr, wdata, hit1, hit2, fwd_data1, fwd_data2, count
  );

  modport master (
    output m_valid, m_waddr, m_wdata, a_valid, a_waddr, a_wdata, raddr1, raddr2,
    input  m_ready, a_ready, wen, waddr, wdata, hit1, hit2, fwd_data1, fwd_data2, count
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Write-back queue: merges memory and ALU register writes into one FIFO draining to the RF port.
// Optional macro WB_FORWARD_EN: forward the youngest pending value to decode on a snoop hit.
module reg_wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_wb_queue_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [CW-1:0]         count_r;

  logic                  m_push_s;
  logic                  a_push_s;
  logic                  pop_s;
  logic [PW-1:0]         a_slot_s;
  logic                  match1_s;
  logic                  match2_s;
  logic                  hit1_s;
  logic                  hit2_s;
  logic [DATA_WIDTH-1:0] fwd1_s;
  logic [DATA_WIDTH-1:0] fwd2_s;

  // The ALU needs two free slots so a memory return can always be accepted behind it.
  assign bus.m_ready = (count_r != CW'(DEPTH));
  assign bus.a_ready = (count_r <  CW'(DEPTH - 1));

  assign m_push_s = bus.m_valid & bus.m_ready & (bus.m_waddr != {ADDR_WIDTH{1'b0}});
  assign a_push_s = bus.a_valid & bus.a_ready & (bus.a_waddr != {ADDR_WIDTH{1'b0}});
  assign pop_s    = (count_r != {CW{1'b0}});
  assign a_slot_s = m_push_s ? (wr_ptr_r + PW'(1'b1)) : wr_ptr_r;

  assign bus.wen   = pop_s;
  assign bus.waddr = addr_mem_r[rd_ptr_r];
  assign bus.wdata = data_mem_r[rd_ptr_r];
  assign bus.count = count_r;

  // Snoop occupied entries oldest to youngest so the last match is the youngest.
  always_comb begin
    match1_s = 1'b0;
    match2_s = 1'b0;
    hit1_s   = 1'b0;
    hit2_s   = 1'b0;
    fwd1_s   = {DATA_WIDTH{1'b0}};
    fwd2_s   = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      match1_s = (CW'(k) < count_r) && (bus.raddr1 != {ADDR_WIDTH{1'b0}}) &&
                 (addr_mem_r[rd_ptr_r + PW'(k)] == bus.raddr1);
      match2_s = (CW'(k) < count_r) && (bus.raddr2 != {ADDR_WIDTH{1'b0}}) &&
                 (addr_mem_r[rd_ptr_r + PW'(k)] == bus.raddr2);
      hit1_s   = hit1_s | match1_s;
      hit2_s   = hit2_s | match2_s;
`ifdef WB_FORWARD_EN
      fwd1_s   = match1_s ? data_mem_r[rd_ptr_r + PW'(k)] : fwd1_s;
      fwd2_s   = match2_s ? data_mem_r[rd_ptr_r + PW'(k)] : fwd2_s;
`endif
    end
  end

  assign bus.hit1      = hit1_s;
  assign bus.hit2      = hit2_s;
  assign bus.fwd_data1 = fwd1_s;
  assign bus.fwd_data2 = fwd2_s;

  // Queue storage, pointers and occupancy; memory entry lands before the ALU entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_WIDTH{1'b0}};
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (m_push_s) begin
        addr_mem_r[wr_ptr_r] <= bus.m_waddr;
        data_mem_r[wr_ptr_r] <= bus.m_wdata;
      end
      if (a_push_s) begin
        addr_mem_r[a_slot_s] <= bus.a_waddr;
        data_mem_r[a_slot_s] <= bus.a_wdata;
      end
      wr_ptr_r <= wr_ptr_r + PW'(m_push_s) + PW'(a_push_s);
      rd_ptr_r <= rd_ptr_r + PW'(pop_s);
      count_r  <= count_r + CW'(m_push_s) + CW'(a_push_s) - CW'(pop_s);
    end
  end
endmodule

// File: doc/reg_wb_queue.md
# reg_wb_queue

Write-back queue between the execute/memory stages and the register file's single write port. It accepts register-write requests from two producers, the ALU result path and the memory load-return path, and orders them in one FIFO. It drains one entry per cycle onto the register file's `wen/waddr/wdata` port. It also reports to decode whether a source register still has a write in flight, with optional forwarding of the youngest pending value.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of register data
- `ADDR_WIDTH`, 5, register index width
- `DEPTH`, 4, FIFO entries; power of two, ≥2

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `m_valid`  in  1  memory-stage write request valid
- `m_ready`  out  1  memory request accepted when `m_valid & m_ready`
- `m_waddr`  in  ADDR_WIDTH  memory request destination register
- `m_wdata`  in  DATA_WIDTH  memory request data
- `a_valid`  in  1  ALU write request valid
- `a_ready`  out  1  ALU request accepted when `a_valid & a_ready`
- `a_waddr`  in  ADDR_WIDTH  ALU request destination register
- `a_wdata`  in  DATA_WIDTH  ALU request data
- `wen`  out  1  register file write enable
- `waddr`  out  ADDR_WIDTH  register file write address
- `wdata`  out  DATA_WIDTH  register file write data
- `raddr1`, `raddr2`  in  ADDR_WIDTH  decode source registers to snoop
- `hit1`, `hit2`  out  1  pending write to `raddr1` / `raddr2`
- `fwd_data1`, `fwd_data2`  out  DATA_WIDTH  forwarded value (see Configuration)
- `count`  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular FIFO with read pointer, write pointer and registered `count`.
- `m_ready = (DEPTH - count) >= 1`.
- `a_ready = (DEPTH - count) >= 2`, which reserves a slot for the memory path.
- Both readies derive from the registered `count` only. Readies have no combinational dependence on any `*_valid` and take no credit for the same-cycle pop.
- Requests with `waddr == 0` are handshaken normally but discarded and never enqueued. This is consistent with r0 being hard-wired to zero.
- Simultaneous accepts: the memory entry is enqueued first (older instruction), then the ALU entry. `count` increases by 2 minus any pop.
- Drain: `wen = (count != 0)`. `waddr/wdata` always show the head entry. The head pops on every edge where `wen = 1`, and the register file consumes it on that same edge.
- Snoop: `hit1 = (raddr1 != 0)` and any occupied entry, including the head currently on the write port, has `waddr == raddr1`. `hit2` is defined the same way for `raddr2`. Requests presented in the current cycle are not snooped.
- Arithmetic: pointers wrap modulo `DEPTH`. `count` never exceeds `DEPTH` and never underflows.
- Asynchronous reset values:
  - `count = 0`, pointers = 0.
  - `wen = 0`, `hit1 = hit2 = 0`.
  - `m_ready = a_ready = 1`, `fwd_data1/2 = 0`.
- Reset mid-operation discards all pending entries with no write issued.

## Timing
- Latency: a request accepted at edge N into an empty queue appears on `wen/waddr/wdata` during cycle N+1 and is written at edge N+1.
- With simultaneous accepts into an empty queue, the memory entry is written at edge N+1 and the ALU entry at edge N+2.
- Throughput is one write per cycle. Sustained dual-producer traffic back-pressures the ALU first.
- Full (`count == DEPTH`): both readies are 0. Pop still proceeds.
- `count == DEPTH-1`: only `m_ready` is 1.
- Empty: `wen = 0`, `waddr/wdata` don't care.
- `hit*` and `fwd_data*` are combinational from `raddr*` and the registered queue state. They have no path from `*_valid`.

## Configuration
- `WB_FORWARD_EN` defined: `fwd_data1/2` carry the `wdata` of the youngest occupied entry matching `raddr1/2`, and decode may consume the value on a hit. If there is no hit, the output is 0.
- `WB_FORWARD_EN` undefined: `fwd_data1/2` are tied to 0 and the youngest-match logic is absent. Decode must stall while `hit*` is 1.

## Test plan
- Reset asserted mid-stream with 3 entries queued. Required: `count = 0`, `wen = 0` and `hit1 = 0` immediately. After release, no stale write appears.
- Single ALU write r5 = 0x1234 into an empty queue. Required: next cycle `wen = 1`, `waddr = 5`, `wdata = 0x1234`. Following cycle `wen = 0`.
- Same-cycle memory r3 = 0xA and ALU r3 = 0xB. Required: writes in order 0xA then 0xB. With `WB_FORWARD_EN`, `raddr1 = 3` gives `hit1 = 1` and `fwd_data1 = 0xB` while both entries are pending.
- Fill with dual traffic and no gaps. Required: `a_ready` drops at `count = DEPTH-1`, `m_ready` drops at `count = DEPTH`. No entry is lost or reordered across 100 random requests checked against a model.
- Write to r0 with data 0xFFFF_FFFF. Required: handshake completes, `count` unchanged, `wen` never asserted, and `raddr1 = 0` gives `hit1 = 0`.
- Without `WB_FORWARD_EN`, queue r7. Required: `hit1 = 1` with `fwd_data1 = 0` until the write edge, then `hit1 = 0`.
